i2c_rx: RTL and testbench
=========================

# i2c_rx

Controller-side I2C byte receiver: while the bus controller clocks SCL, it samples eight SDA bits MSB-first from the addressed target, then drives the ACK/NAK bit. It sits beside the controller's byte transmitter and shares the same `i2c_if` bus and SCL generator. It serves the read phase of a transaction, after the address byte has been sent and acknowledged. START/STOP generation and SCL generation are outside this block.

## Interface
- `TIMEOUT`, 65535: `clk` cycles without an SCL edge before a byte is aborted, counted while not idle.
- `clk`  input  1  system clock; all logic on rising edge.
- `rst`  input  1  synchronous, active-high reset.
- `i2c`  modport  `i2c_if.ctrl_rx`  bus signals.
  - `scl` is input only.
  - `sda` is open-drain: the block drives only `1'b0` or `'bZ`.
- `rx`  input  1  receive request, active high; level-sensitive.
- `ack_in`  input  1  1 = ACK the byte (more wanted), 0 = NAK (last byte).
- `data`  output  8  received byte; holds its value until the next byte completes.
- `data_valid`  output  1  one-cycle pulse when `data` updates.
- `last`  output  1  qualified by `data_valid`; 1 = this byte was NAKed.
- `busy`  output  1  high in any state except IDLE.
- `timeout`  output  1  one-cycle pulse on abort.

## Operation
- States: IDLE, SHIFT, ACK.
- Edge detection:
  - `scl_q` is a register holding the previous `scl`.
  - rise = `scl & !scl_q`; fall = `!scl & scl_q`.
- IDLE:
  - SDA released, bit counter = 7, timeout counter = 0.
  - Go to SHIFT when `rx` is high and `scl` is low.
  - If `rx` is high while `scl` is high, stay in IDLE until `scl` goes low.
- SHIFT:
  - On each rise, `shreg[cnt] <= sda`.
  - On the rise with `cnt == 0`, also latch `ack_in` into `ack_q`.
  - On a fall with `cnt != 0`, decrement `cnt`.
  - On the fall following the `cnt == 0` rise:
    - `data <= shreg` (with bit 0 taken from the sampled value);
    - pulse `data_valid`; `last <= !ack_q`;
    - go to ACK.
- ACK:
  - SDA is driven low if `ack_q`, released otherwise.
  - On the next rise after entering ACK, nothing is sampled; SDA is held.
  - On the following fall, release SDA.
    - If `ack_q & rx`: `cnt <= 7`, go to SHIFT.
    - Otherwise go to IDLE.
- `rx` is examined only in IDLE and at ACK exit. Deasserting `rx` mid-byte does not abort the byte.
- The timeout counter resets on every rise/fall. If it reaches `TIMEOUT - 1` in SHIFT or ACK:
  - pulse `timeout`;
  - release SDA;
  - go to IDLE;
  - `data` and `data_valid` are unaffected (no partial byte is delivered).
- Counter width: `$clog2(TIMEOUT+1)`, saturating; no wrap.

## Timing
- Reset values: `data = 8'h00`, `data_valid = 0`, `last = 0`, `busy = 0`, `timeout = 0`, SDA = `'bZ`, state = IDLE, `cnt = 7`, `scl_q = 0`.
- `rst` asserted mid-byte: SDA is released on the next clock edge and the partial byte is discarded. No `data_valid` and no `timeout` pulse.
- Edge detection latency: one cycle after `scl` changes at the port.
- SDA sampling happens on the cycle the rise is detected.
- `data`/`data_valid`/`last` change on the clock edge after the 8th fall is detected, i.e. 2 cycles after SCL falls.
- SDA drive for ACK begins on that same edge.
- SDA release happens on the edge after the ACK-clock fall is detected. Hold time after SCL falls is therefore 2 cycles.
- Back-to-back bytes: the first SHIFT rise may occur at any time after ACK exit. There is no dead cycle.
- `busy` is registered and equals (state != IDLE).

## Configuration
- `I2C_RX_SYNC_EN`:
  - Defined: `scl` and `sda` each pass through a 2-flop synchronizer before edge detection and sampling. All input-referred latencies grow by 2 cycles; for example, SDA release becomes 4 cycles after SCL falls.
  - Undefined: raw `scl`/`sda` are used directly. The SCL generator must then share `clk`.

## Test plan
- Single-byte read:
  - Stimulus: `rx = 1`, `ack_in = 0`, target sends `8'hA5`.
  - Response: one `data_valid` pulse with `data = 8'hA5` and `last = 1`; SDA released during the ACK clock; then IDLE with `busy = 0`.
- Two-byte read:
  - Stimulus: `ack_in = 1` on byte 1, target sends `8'h3C`; `ack_in = 0` on byte 2, target sends `8'hF0`.
  - Response: SDA low through the byte-1 ACK clock, released 2 cycles after its fall; then `data = 8'h3C` (`last = 0`) and `data = 8'hF0` (`last = 1`).
- `rx` dropped after bit 3 of a byte sent with `ack_in = 1`:
  - Response: byte still delivered, SDA driven low for the ACK, then IDLE (no second byte).
- Reset mid-byte:
  - Stimulus: `rst` for 1 cycle after the 4th bit while SDA is idle.
  - Response: all outputs at reset values; no `data_valid`.
  - Repeat during the ACK bit: SDA is `'bZ` on the next edge.
- Timeout:
  - Stimulus: SCL stalls high for `TIMEOUT` cycles mid-byte, with `TIMEOUT = 16`.
  - Response: `timeout` pulses exactly once, SDA is released, state returns to IDLE, `data` is unchanged.
- Build with `I2C_RX_SYNC_EN` defined and rerun the two-byte read:
  - Response: same data; `data_valid` and SDA release each 2 cycles later than in the unsynchronized build.

Source files
------------

// File: rtl/i2c_rx_if.sv
// i2c_if: shared I2C bus bundle. SDA is open-drain: each side only pulls the line low,
// and the line reads high when nobody pulls (wired-AND with an implied pull-up).
interface i2c_if;
    logic scl;
    logic sda_tgt_low;
    logic sda_rx_low;
    logic sda;

    assign sda = ~(sda_tgt_low | sda_rx_low);

    modport ctrl_rx (input scl, input sda, output sda_rx_low);
    modport tgt     (input scl, input sda, output sda_tgt_low);
endinterface

// File: rtl/i2c_rx.sv
// i2c_rx: controller-side I2C byte receiver; samples 8 SDA bits MSB-first, then drives ACK/NAK.
// Macro I2C_RX_SYNC_EN: pass scl/sda through 2-flop synchronizers before use.
module i2c_rx #(
    parameter int TIMEOUT = 65535
) (
    input  logic       clk,
    input  logic       rst,
    i2c_if.ctrl_rx     i2c,
    input  logic       rx,
    input  logic       ack_in,
    output logic [7:0] data,
    output logic       data_valid,
    output logic       last,
    output logic       busy,
    output logic       timeout
);
    localparam int TW = $clog2(TIMEOUT + 1);
    localparam logic [TW-1:0] TCNT_LAST = TW'(TIMEOUT - 1);
    localparam logic [TW-1:0] TCNT_MAX  = TW'(TIMEOUT);

    typedef enum logic [1:0] {IDLE, SHIFT, ACK} state_t;

    function automatic logic [TW-1:0] sat_inc(input logic [TW-1:0] v);
        return (v == TCNT_MAX) ? v : v + TW'(1);
    endfunction

    logic scl_s;
    logic sda_s;

`ifdef I2C_RX_SYNC_EN
    logic [1:0] scl_sync;
    logic [1:0] sda_sync;

    always_ff @(posedge clk) begin
        if (rst) begin
            scl_sync <= 2'b00;
            sda_sync <= 2'b11;
        end else begin
            scl_sync <= {scl_sync[0], i2c.scl};
            sda_sync <= {sda_sync[0], i2c.sda};
        end
    end

    assign scl_s = scl_sync[1];
    assign sda_s = sda_sync[1];
`else
    assign scl_s = i2c.scl;
    assign sda_s = i2c.sda;
`endif

    // stage p1: registered SCL edge flags; the FSM acts on them one edge later
    logic scl_q;
    logic rise_p1;
    logic fall_p1;

    always_ff @(posedge clk) begin
        if (rst) begin
            scl_q   <= 1'b0;
            rise_p1 <= 1'b0;
            fall_p1 <= 1'b0;
        end else begin
            scl_q   <= scl_s;
            rise_p1 <= scl_s & ~scl_q;
            fall_p1 <= ~scl_s & scl_q;
        end
    end

    state_t          state, state_n;
    logic [2:0]      cnt, cnt_n;
    logic [7:0]      shreg, shreg_n;
    logic            ack_q, ack_n;
    logic [TW-1:0]   tcnt, tcnt_n;
    logic            sda_low, sda_low_n;
    logic [7:0]      data_n;
    logic            valid_n;
    logic            last_n;
    logic            timeout_n;

    // sda_rx_low = 1 pulls SDA to 0; otherwise the line is left floating
    assign i2c.sda_rx_low = sda_low;

    always_comb begin
        state_n   = state;
        cnt_n     = cnt;
        shreg_n   = shreg;
        ack_n     = ack_q;
        tcnt_n    = tcnt;
        sda_low_n = sda_low;
        data_n    = data;
        valid_n   = 1'b0;
        last_n    = last;
        timeout_n = 1'b0;
        case (state)
            IDLE: begin
                sda_low_n = 1'b0;
                cnt_n     = 3'd7;
                tcnt_n    = '0;
                if (rx && !scl_q) state_n = SHIFT;
            end
            SHIFT, ACK: begin
                if (rise_p1 || fall_p1) tcnt_n = '0;
                else                    tcnt_n = sat_inc(tcnt);
                if (tcnt == TCNT_LAST) begin
                    timeout_n = 1'b1;
                    sda_low_n = 1'b0;
                    state_n   = IDLE;
                end else if (state == SHIFT) begin
                    if (rise_p1) begin
                        shreg_n[cnt] = sda_s;
                        if (cnt == 3'd0) ack_n = ack_in;
                    end else if (fall_p1) begin
                        if (cnt != 3'd0) begin
                            cnt_n = cnt - 3'd1;
                        end else begin
                            data_n    = shreg;
                            valid_n   = 1'b1;
                            last_n    = ~ack_q;
                            sda_low_n = ack_q;
                            state_n   = ACK;
                        end
                    end
                end else if (fall_p1) begin
                    // the ACK-clock rise is ignored; its fall ends the ACK bit
                    sda_low_n = 1'b0;
                    if (ack_q && rx) begin
                        cnt_n   = 3'd7;
                        state_n = SHIFT;
                    end else begin
                        state_n = IDLE;
                    end
                end
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            cnt        <= 3'd7;
            shreg      <= '0;
            ack_q      <= 1'b0;
            tcnt       <= '0;
            sda_low    <= 1'b0;
            data       <= '0;
            data_valid <= 1'b0;
            last       <= 1'b0;
            busy       <= 1'b0;
            timeout    <= 1'b0;
        end else begin
            state      <= state_n;
            cnt        <= cnt_n;
            shreg      <= shreg_n;
            ack_q      <= ack_n;
            tcnt       <= tcnt_n;
            sda_low    <= sda_low_n;
            data       <= data_n;
            data_valid <= valid_n;
            last       <= last_n;
            busy       <= (state_n != IDLE);
            timeout    <= timeout_n;
        end
    end
endmodule

// File: tb/tb_i2c_rx.sv
// tb_i2c_rx: drives an I2C target + SCL on the shared bus and checks received bytes,
// ACK/NAK drive timing, mid-byte reset and timeout behaviour of i2c_rx.
module tb_i2c_rx;
    localparam int TO = 16;
    localparam int H  = 6;
`ifdef I2C_RX_SYNC_EN
    localparam int S = 2;
`else
    localparam int S = 0;
`endif

    logic       clk = 1'b0;
    logic       rst;
    logic       rx;
    logic       ack_in;
    logic [7:0] data;
    logic       data_valid;
    logic       last;
    logic       busy;
    logic       timeout;

    i2c_if bus();

    i2c_rx #(.TIMEOUT(TO)) dut (
        .clk        (clk),
        .rst        (rst),
        .i2c        (bus),
        .rx         (rx),
        .ack_in     (ack_in),
        .data       (data),
        .data_valid (data_valid),
        .last       (last),
        .busy       (busy),
        .timeout    (timeout)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    int tout_cnt = 0;
    int fall8 = 0;
    logic [7:0] dv_data[$];
    bit         dv_last[$];
    int         dv_cyc[$];

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (data_valid) begin
            dv_data.push_back(data);
            dv_last.push_back(last);
            dv_cyc.push_back(cyc);
        end
        if (timeout) tout_cnt = tout_cnt + 1;
    end

    typedef struct {
        logic [7:0] b;
        bit         ack;
        bit         drop;
        bit         fin;
        logic [7:0] exp_data;
        bit         exp_last;
    } vec_t;

    vec_t vecs[4];

    task automatic wait_edges(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
        end
    endtask

    task automatic bit_clk(input bit v);
        bus.sda_tgt_low = ~v;
        wait_edges(H);
        bus.scl = 1'b1;
        wait_edges(H);
        bus.scl = 1'b0;
        fall8 = cyc;
    endtask

    task automatic chk_dv(input logic [7:0] exp_data, input bit exp_last, input bit chk_lat);
        chk("dv_count", dv_data.size(), 1);
        if (dv_data.size() != 0) begin
            chk("data", dv_data[0], exp_data);
            chk("last", dv_last[0], exp_last);
            if (chk_lat) chk("dv_latency", dv_cyc[0] - fall8, 2 + S);
        end
        dv_data.delete();
        dv_last.delete();
        dv_cyc.delete();
    endtask

    // full byte plus ACK clock; SDA during the ACK bit must read high exactly when the byte is NAKed
    task automatic send_byte(input logic [7:0] b, input bit ack, input bit drop, input bit fin,
                             input logic [7:0] exp_data, input bit exp_last);
        ack_in = ack;
        for (int i = 7; i >= 0; i--) begin
            bit_clk(b[i]);
            if (drop && i == 4) rx = 1'b0;
        end
        bus.sda_tgt_low = 1'b0;
        wait_edges(H);
        chk("ack_drive", bus.sda, exp_last);
        bus.scl = 1'b1;
        if (fin) rx = 1'b0;
        wait_edges(H);
        chk("ack_high", bus.sda, exp_last);
        bus.scl = 1'b0;
        for (int e = 1; e <= H; e++) begin
            wait_edges(1);
            if (e == 1 + S) chk("ack_hold", bus.sda, exp_last);
            if (e == 2 + S) chk("ack_release", bus.sda, 1);
        end
        chk("busy_after", busy, fin ? 0 : 1);
        chk_dv(exp_data, exp_last, 1'b1);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int         n;
        bit         in_txn;
        bit         fin;
        logic [7:0] rb;
        int         t_before;

        vecs[0] = '{8'hA5, 1'b0, 1'b0, 1'b1, 8'hA5, 1'b1};
        vecs[1] = '{8'h3C, 1'b1, 1'b0, 1'b0, 8'h3C, 1'b0};
        vecs[2] = '{8'hF0, 1'b0, 1'b0, 1'b1, 8'hF0, 1'b1};
        vecs[3] = '{8'h5A, 1'b1, 1'b1, 1'b1, 8'h5A, 1'b0};

        rst = 1'b1;
        rx = 1'b0;
        ack_in = 1'b0;
        bus.scl = 1'b0;
        bus.sda_tgt_low = 1'b0;
        wait_edges(3);
        rst = 1'b0;
        wait_edges(1);
        chk("rst_data", data, 8'h00);
        chk("rst_valid", data_valid, 0);
        chk("rst_last", last, 0);
        chk("rst_busy", busy, 0);
        chk("rst_timeout", timeout, 0);
        chk("rst_sda", bus.sda, 1);

        in_txn = 1'b0;
        for (int k = 0; k < 4; k++) begin
            if (!in_txn) begin
                rx = 1'b1;
                wait_edges(2);
            end
            send_byte(vecs[k].b, vecs[k].ack, vecs[k].drop, vecs[k].fin,
                      vecs[k].exp_data, vecs[k].exp_last);
            in_txn = ~vecs[k].fin;
            if (vecs[k].fin) wait_edges(4);
        end

        // randomized reads: every byte is ACKed except the final one, which is NAKed
        for (int t = 0; t < 10; t++) begin
            n = $urandom_range(1, 4);
            rx = 1'b1;
            wait_edges(2);
            for (int k = 0; k < n; k++) begin
                rb  = 8'($urandom);
                fin = (k == n - 1);
                send_byte(rb, ~fin, 1'b0, fin, rb, fin);
            end
            wait_edges(4);
        end
        chk("no_spurious_timeout", tout_cnt, 0);

        // reset after the 4th bit
        rx = 1'b1;
        wait_edges(2);
        ack_in = 1'b1;
        for (int i = 0; i < 4; i++) bit_clk(i[0]);
        bus.sda_tgt_low = 1'b0;
        wait_edges(2);
        chk("busy_mid", busy, 1);
        rst = 1'b1;
        rx = 1'b0;
        wait_edges(1);
        rst = 1'b0;
        chk("mrst_data", data, 8'h00);
        chk("mrst_valid", data_valid, 0);
        chk("mrst_last", last, 0);
        chk("mrst_busy", busy, 0);
        chk("mrst_sda", bus.sda, 1);
        wait_edges(H);
        chk("mrst_no_dv", dv_data.size(), 0);
        chk("mrst_no_tout", tout_cnt, 0);

        // reset during the ACK bit
        rx = 1'b1;
        wait_edges(2);
        ack_in = 1'b1;
        for (int i = 7; i >= 0; i--) bit_clk(1'(8'h96 >> i));
        bus.sda_tgt_low = 1'b0;
        wait_edges(H);
        chk("arst_ack_low", bus.sda, 0);
        bus.scl = 1'b1;
        wait_edges(2);
        rst = 1'b1;
        rx = 1'b0;
        wait_edges(1);
        rst = 1'b0;
        chk("arst_sda", bus.sda, 1);
        chk("arst_data", data, 8'h00);
        chk("arst_busy", busy, 0);
        bus.scl = 1'b0;
        wait_edges(H);
        chk_dv(8'h96, 1'b0, 1'b0);
        chk("arst_no_tout", tout_cnt, 0);

        // known byte, then stall SCL high mid-byte
        rx = 1'b1;
        wait_edges(2);
        send_byte(8'h69, 1'b0, 1'b0, 1'b1, 8'h69, 1'b1);
        wait_edges(4);
        t_before = tout_cnt;
        rx = 1'b1;
        wait_edges(2);
        ack_in = 1'b0;
        for (int i = 0; i < 3; i++) bit_clk(1'b0);
        bus.sda_tgt_low = 1'b0;
        wait_edges(H);
        bus.scl = 1'b1;
        rx = 1'b0;
        wait_edges(10);
        chk("tout_early", tout_cnt - t_before, 0);
        chk("tout_busy_early", busy, 1);
        wait_edges(TO + 6);
        chk("tout_once", tout_cnt - t_before, 1);
        chk("tout_busy", busy, 0);
        chk("tout_sda", bus.sda, 1);
        chk("tout_data", data, 8'h69);
        chk("tout_no_dv", dv_data.size(), 0);
        bus.scl = 1'b0;
        wait_edges(H);
        chk("tout_still_once", tout_cnt - t_before, 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
